// File: rtl/count_compare_pwm_pkg.sv
// Shared definitions for the count/compare PWM block: state encoding, config selectors,
// default data width.
package count_compare_pwm_pkg;

    // Width of count, PERIOD and DUTY; must match the upstream event counter.
    localparam int unsigned DefBitSz = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

    localparam logic CfgPeriod = 1'b0;
    localparam logic CfgDuty   = 1'b1;

    // RUN and STOPPING both keep the comparators live.
    function automatic logic is_running(state_e s);
        return s != StIdle;
    endfunction

endpackage

// File: rtl/count_compare_pwm_if.sv
// Bus bundle between software/counter side (master) and the compare block (slave).
interface count_compare_pwm_if #(
    parameter int unsigned BitSz = 16
);
    logic [BitSz-1:0] count;
    logic             count_en;
    logic             start;
    logic             stop;
    logic             cfg_wr;
    logic             cfg_sel;
    logic [BitSz-1:0] cfg_data;
    logic             irq_clr;
    logic             cnt_clear;
    logic             pwm_out;
    logic             period_evt;
    logic             irq;
    logic             busy;

    modport master (
        output count, count_en, start, stop, cfg_wr, cfg_sel, cfg_data, irq_clr,
        input  cnt_clear, pwm_out, period_evt, irq, busy
    );

    modport slave (
        input  count, count_en, start, stop, cfg_wr, cfg_sel, cfg_data, irq_clr,
        output cnt_clear, pwm_out, period_evt, irq, busy
    );

endinterface

// File: rtl/count_compare_pwm_cmp_shadow_reg.sv
// Shadow + active register pair for one compare value.
// Macro CMP_SHADOW_EN: defined -> writes land in the shadow and reach the active copy on
// reload; undefined -> a single register written directly.
module cmp_shadow_reg #(
    parameter int unsigned      BitSz    = 16,
    parameter logic [BitSz-1:0] ResetVal = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_i,
    input  logic [BitSz-1:0] wr_data_i,
    input  logic             reload_i,
    output logic [BitSz-1:0] act_o
);

    logic [BitSz-1:0] act_q, act_d;

`ifdef CMP_SHADOW_EN
    logic [BitSz-1:0] sh_q, sh_d;

    // Reload samples the old shadow, so a write in the reload cycle waits one boundary.
    always_comb begin
        sh_d  = wr_i ? wr_data_i : sh_q;
        act_d = reload_i ? sh_q : act_q;
    end

    // Shadow register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_q <= ResetVal;
        end else begin
            sh_q <= sh_d;
        end
    end
`else
    logic unused_reload;
    assign unused_reload = reload_i;

    // Direct write, effective next clock.
    always_comb begin
        act_d = wr_i ? wr_data_i : act_q;
    end
`endif

    // Active register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_q <= ResetVal;
        end else begin
            act_q <= act_d;
        end
    end

    assign act_o = act_q;

endmodule

// File: rtl/count_compare_pwm.sv
// Count/compare PWM: compares the upstream count against PERIOD/DUTY, drives the counter's
// synchronous clear, and produces PWM, period event and sticky irq.
// Macro CMP_SHADOW_EN enables shadowed PERIOD/DUTY reloaded at period boundaries.
module count_compare_pwm
    import count_compare_pwm_pkg::*;
#(
    parameter int unsigned BitSz = DefBitSz
) (
    input logic                clock,
    input logic                reset_n,
    count_compare_pwm_if.slave bus
);

    state_e           state_q, state_d;
    logic             running;
    logic             cnt_clear;
    logic             reload;
    logic [BitSz-1:0] period_act;
    logic [BitSz-1:0] duty_act;
    logic             pwm_q, pwm_d;
    logic             evt_q, evt_d;
    logic             irq_q, irq_d;

    assign running   = is_running(state_q);
    assign cnt_clear = running & bus.count_en & (bus.count == period_act);
    // Boundary reload, plus the start pulse so a fresh run uses the latest shadows.
    assign reload    = cnt_clear | ((state_q == StIdle) & bus.start);

    cmp_shadow_reg #(
        .BitSz    (BitSz),
        .ResetVal ({BitSz{1'b1}})
    ) u_period (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_i      (bus.cfg_wr & (bus.cfg_sel == CfgPeriod)),
        .wr_data_i (bus.cfg_data),
        .reload_i  (reload),
        .act_o     (period_act)
    );

    cmp_shadow_reg #(
        .BitSz    (BitSz),
        .ResetVal ({BitSz{1'b0}})
    ) u_duty (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_i      (bus.cfg_wr & (bus.cfg_sel == CfgDuty)),
        .wr_data_i (bus.cfg_data),
        .reload_i  (reload),
        .act_o     (duty_act)
    );

    // Start/stop sequencing; stop only takes effect at the next period boundary.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (bus.stop)  state_d = StStop;
            StStop:  if (cnt_clear) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output next-state: PWM compare, event follows clear, irq set beats clear.
    always_comb begin
        pwm_d = running & (bus.count < duty_act);
        evt_d = cnt_clear;
        irq_d = evt_q ? 1'b1 : (bus.irq_clr ? 1'b0 : irq_q);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pwm_q   <= 1'b0;
            evt_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_d;
            evt_q   <= evt_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.cnt_clear  = cnt_clear;
    assign bus.pwm_out    = pwm_q;
    assign bus.period_evt = evt_q;
    assign bus.irq        = irq_q;
    assign bus.busy       = running;

endmodule

// File: tb/tb_count_compare_pwm.sv
// Bench: upstream counter + count_compare_pwm; stimulus pushes expectations, a negedge
// monitor pops and compares them.
module tb_count_compare_pwm;
    import count_compare_pwm_pkg::*;

    localparam int unsigned W = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    count_compare_pwm_if #(.BitSz(W)) bus ();

    count_compare_pwm #(.BitSz(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Upstream free-running counter with synchronous clear from the DUT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.count <= '0;
        end else if (bus.cnt_clear) begin
            bus.count <= '0;
        end else if (bus.count_en) begin
            bus.count <= bus.count + 16'd1;
        end
    end

    typedef enum {SelCount, SelPwm, SelEvt, SelIrq, SelBusy, SelClr} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [15:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic expect_val(input string name, input sel_e sel, input logic [15:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        exp_q.push_back(c);
    endtask

    function automatic logic [15:0] b16(input bit x);
        return x ? 16'd1 : 16'd0;
    endfunction

    // Monitor: drain all expectations queued for this cycle.
    always @(negedge clock) begin : monitor
        chk_t        c;
        logic [15:0] act;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            case (c.sel)
                SelCount: act = bus.count;
                SelPwm:   act = b16(bus.pwm_out);
                SelEvt:   act = b16(bus.period_evt);
                SelIrq:   act = b16(bus.irq);
                SelBusy:  act = b16(bus.busy);
                default:  act = b16(bus.cnt_clear);
            endcase
            n_run++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        bus.count_en = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_sel  = 1'b0;
        bus.cfg_data = '0;
        bus.irq_clr  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic cfg_write(input logic sel, input logic [15:0] data);
        bus.cfg_wr   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_data = data;
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    // Leaves the bench at k=0: RUN, count=0, count_en still 0.
    task automatic start_run(input logic [15:0] p, input logic [15:0] d);
        apply_reset();
        cfg_write(CfgPeriod, p);
        cfg_write(CfgDuty, d);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin : stim
        int j;
        int duty;
        int cnt;
        bus.count_en = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_sel  = 1'b0;
        bus.cfg_data = '0;
        bus.irq_clr  = 1'b0;

        // Basic run: PERIOD=9, DUTY=3, irq set/clear interplay.
        start_run(16'd9, 16'd3);
        expect_val("t2 busy after start", SelBusy, 16'd1);
        for (int k = 0; k < 42; k++) begin
            bus.count_en = 1'b1;
            bus.irq_clr  = (k == 30 || k == 32);
            expect_val($sformatf("t2 count k=%0d", k), SelCount, 16'(k % 10));
            expect_val($sformatf("t2 pwm k=%0d", k), SelPwm, b16(k >= 1 && ((k - 1) % 10) < 3));
            expect_val($sformatf("t2 evt k=%0d", k), SelEvt, b16(k >= 10 && (k % 10) == 0));
            expect_val($sformatf("t2 clr k=%0d", k), SelClr, b16((k % 10) == 9));
            expect_val($sformatf("t2 irq k=%0d", k), SelIrq,
                       b16((k >= 11 && k <= 32) || k >= 41));
            tick();
        end
        bus.irq_clr = 1'b0;

        // Asynchronous reset mid-RUN with pwm and irq high.
        reset_n = 1'b0;
        #1;
        n_run++;
        if (bus.pwm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL t1 async pwm: got %b, expected 0", bus.pwm_out);
        end
        n_run++;
        if (bus.irq !== 1'b0) begin
            n_fail++;
            $display("FAIL t1 async irq: got %b, expected 0", bus.irq);
        end
        n_run++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t1 async busy: got %b, expected 0", bus.busy);
        end
        n_run++;
        if (bus.period_evt !== 1'b0) begin
            n_fail++;
            $display("FAIL t1 async evt: got %b, expected 0", bus.period_evt);
        end
        expect_val("t1 rst count", SelCount, 16'd0);
        expect_val("t1 rst pwm", SelPwm, 16'd0);
        expect_val("t1 rst evt", SelEvt, 16'd0);
        expect_val("t1 rst irq", SelIrq, 16'd0);
        expect_val("t1 rst busy", SelBusy, 16'd0);
        expect_val("t1 rst clr", SelClr, 16'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.count_en = 1'b1;
            expect_val($sformatf("t1 idle busy k=%0d", k), SelBusy, 16'd0);
            expect_val($sformatf("t1 idle clr k=%0d", k), SelClr, 16'd0);
            expect_val($sformatf("t1 idle pwm k=%0d", k), SelPwm, 16'd0);
            expect_val($sformatf("t1 idle count k=%0d", k), SelCount, 16'(k));
            tick();
        end

        // Limits: DUTY=0, DUTY>PERIOD, PERIOD=0.
        start_run(16'd9, 16'd0);
        for (int k = 0; k < 25; k++) begin
            bus.count_en = 1'b1;
            expect_val($sformatf("t3 duty0 pwm k=%0d", k), SelPwm, 16'd0);
            tick();
        end
        start_run(16'd9, 16'd12);
        for (int k = 0; k < 25; k++) begin
            bus.count_en = 1'b1;
            expect_val($sformatf("t3 duty12 pwm k=%0d", k), SelPwm, b16(k >= 1));
            tick();
        end
        start_run(16'd0, 16'd0);
        for (int k = 0; k < 10; k++) begin
            bus.count_en = 1'b1;
            expect_val($sformatf("t3 p0 count k=%0d", k), SelCount, 16'd0);
            expect_val($sformatf("t3 p0 clr k=%0d", k), SelClr, 16'd1);
            expect_val($sformatf("t3 p0 evt k=%0d", k), SelEvt, b16(k >= 1));
            tick();
        end

        // Stop at count=4, ignored stop in IDLE, start+stop together from IDLE.
        start_run(16'd9, 16'd3);
        for (int k = 0; k < 22; k++) begin
            bus.count_en = 1'b1;
            bus.stop     = (k == 4 || k == 16 || k == 18);
            bus.start    = (k == 18);
            cnt = (k <= 9) ? k : ((k <= 19) ? k - 10 : k - 20);
            expect_val($sformatf("t4 busy k=%0d", k), SelBusy, b16(k <= 9 || k >= 19));
            expect_val($sformatf("t4 count k=%0d", k), SelCount, 16'(cnt));
            expect_val($sformatf("t4 clr k=%0d", k), SelClr, b16(k == 9 || k == 19));
            expect_val($sformatf("t4 pwm k=%0d", k), SelPwm, b16((k >= 1 && k <= 3) || k == 21));
            expect_val($sformatf("t4 evt k=%0d", k), SelEvt, b16(k == 10 || k == 20));
            tick();
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;

        // DUTY rewrite at count=2, then again in a wrap cycle.
        start_run(16'd9, 16'd3);
        for (int k = 0; k < 41; k++) begin
            bus.count_en = 1'b1;
            bus.cfg_wr   = (k == 2 || k == 19);
            bus.cfg_sel  = CfgDuty;
            bus.cfg_data = (k == 19) ? 16'd5 : 16'd7;
            j = k - 1;
`ifdef CMP_SHADOW_EN
            duty = (j < 10) ? 3 : ((j < 30) ? 7 : 5);
`else
            duty = (j < 3) ? 3 : ((j < 20) ? 7 : 5);
`endif
            expect_val($sformatf("t5 count k=%0d", k), SelCount, 16'(k % 10));
            expect_val($sformatf("t5 pwm k=%0d", k), SelPwm, b16(k >= 1 && (j % 10) < duty));
            tick();
        end
        bus.cfg_wr = 1'b0;

        // count_en toggling stretches the period to 20 clocks.
        start_run(16'd9, 16'd3);
        for (int k = 0; k < 45; k++) begin
            bus.count_en = ((k % 2) == 1);
            expect_val($sformatf("t6 count k=%0d", k), SelCount, 16'((k % 20) / 2));
            expect_val($sformatf("t6 clr k=%0d", k), SelClr, b16((k % 20) == 19));
            expect_val($sformatf("t6 evt k=%0d", k), SelEvt, b16(k >= 20 && (k % 20) == 0));
            expect_val($sformatf("t6 pwm k=%0d", k), SelPwm,
                       b16(k >= 1 && (((k - 1) % 20) / 2) < 3));
            tick();
        end
        bus.count_en = 1'b0;

        tick();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        if (n_fail == 0 && n_run > 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
